// File: rtl/video_timing_pattern_gen.sv
// Raster timing and test-pattern source for the TMDS path.
// Optional: define PATTERN_SCROLL_EN for per-frame scrolling of ramp/checker.
module video_timing_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [10:0] sx,
  output logic [10:0] sy,
  output logic        hsync,
  output logic        vsync,
  output logic        screen_area,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HT_M1  = 11'(H_TOTAL - 1);
  localparam logic [10:0] VT_M1  = 11'(V_TOTAL - 1);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] BAR_M1 = 11'(H_ACTIVE / 8 - 1);
  localparam logic [10:0] THIRD1 = 11'(H_ACTIVE / 3);
  localparam logic [10:0] THIRD2 = 11'(2 * H_ACTIVE / 3);
  localparam logic        HSP    = (HS_POL != 0);
  localparam logic        VSP    = (VS_POL != 0);

  logic [10:0] hx, vy;
  logic [2:0]  pat, pat_eff;
  logic        en_d;
  logic [2:0]  bar_idx;
  logic [10:0] bar_px;
  logic        line_end, frame_end;
  logic [7:0]  px;
  logic        act_n, hs_n, vs_n;
  logic [23:0] rgb_n, bar_rgb;

  assign line_end  = (hx == HT_M1);
  assign frame_end = line_end && (vy == VT_M1);
  // The first enabled cycle already shows the newly requested pattern.
  assign pat_eff   = (en && !en_d) ? pattern_sel : pat;

`ifdef PATTERN_SCROLL_EN
  logic [7:0] frame_cnt;

  // Frame counter advances once per completed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt <= 8'd0;
    else if (en && frame_end)
      frame_cnt <= frame_cnt + 8'd1;
  end

  assign px = hx[7:0] + frame_cnt;
`else
  assign px = hx[7:0];
`endif

  // Raster counters, held at the origin while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hx <= 11'd0;
      vy <= 11'd0;
    end else if (!en) begin
      hx <= 11'd0;
      vy <= 11'd0;
    end else begin
      hx <= line_end ? 11'd0 : hx + 11'd1;
      if (line_end)
        vy <= (vy == VT_M1) ? 11'd0 : vy + 11'd1;
    end
  end

  // Bar index tracks hx, stepping every BAR_W pixels and saturating at 7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_idx <= 3'd0;
      bar_px  <= 11'd0;
    end else if (!en || line_end) begin
      bar_idx <= 3'd0;
      bar_px  <= 11'd0;
    end else if (bar_px == BAR_M1) begin
      bar_px  <= 11'd0;
      if (bar_idx != 3'd7)
        bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px  <= bar_px + 11'd1;
    end
  end

  // Pattern selection is latched only at frame boundaries or on enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= 3'd0;
      en_d <= 1'b0;
    end else begin
      en_d <= en;
      if (en && (!en_d || frame_end))
        pat <= pattern_sel;
    end
  end

  // Bar colour lookup.
  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // Timing flags and pixel colour for the current counter position.
  always_comb begin
    act_n = (hx < HA) && (vy < VA);
    hs_n  = (hx >= HS_BEG && hx < HS_END) ? HSP : ~HSP;
    vs_n  = (vy >= VS_BEG && vy < VS_END) ? VSP : ~VSP;
    rgb_n = 24'h000000;
    if (act_n) begin
      case (pat_eff)
        3'd0: rgb_n = solid_rgb;
        3'd1: rgb_n = bar_rgb;
        3'd2: rgb_n = (px[5] ^ vy[5]) ? 24'h000000 : 24'hFFFFFF;
        3'd3: rgb_n = {px, px, px};
        3'd4: begin
          if (hx < THIRD1)
            rgb_n = 24'hFF0000;
          else if (hx < THIRD2)
            rgb_n = 24'h00FF00;
          else
            rgb_n = 24'h0000FF;
        end
        default: rgb_n = 24'h000000;
      endcase
    end
  end

  // Output register stage; everything leaves aligned one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx          <= 11'd0;
      sy          <= 11'd0;
      hsync       <= ~HSP;
      vsync       <= ~VSP;
      screen_area <= 1'b0;
      red         <= 8'd0;
      green       <= 8'd0;
      blue        <= 8'd0;
      frame_start <= 1'b0;
    end else if (!en) begin
      sx          <= 11'd0;
      sy          <= 11'd0;
      hsync       <= ~HSP;
      vsync       <= ~VSP;
      screen_area <= 1'b0;
      red         <= 8'd0;
      green       <= 8'd0;
      blue        <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      sx          <= hx;
      sy          <= vy;
      hsync       <= hs_n;
      vsync       <= vs_n;
      screen_area <= act_n;
      red         <= rgb_n[23:16];
      green       <= rgb_n[15:8];
      blue        <= rgb_n[7:0];
      frame_start <= (hx == 11'd0) && (vy == 11'd0);
    end
  end

endmodule
